// File: rtl/apb_reg_slave.sv
// APB completer: NUM_REGS read/write words, a read-only ID word at 0x3C and fixed wait states.
// Define APB_REG_SLAVE_PSLVERR_EN to report decode and permission errors on pslverr_o.
module apb_reg_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_A000,
  parameter int          NUM_REGS    = 4,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hAB00_0001
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic [31:0] reg0_o
);

  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
  localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);
  localparam logic [3:0] ID_OFFSET  = 4'hF;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  idx_q;
  logic        id_q;
  logic        err_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] prdata_q;
  logic        pready_q;
  logic        pslverr_q;
  logic [31:0] regs_q [NUM_REGS];

  logic [3:0]  dec_idx;
  logic        dec_hit;
  logic        dec_id;
  logic        dec_reg;
  logic        dec_err;

  logic [3:0]  sel_idx;
  logic        sel_id;
  logic        sel_err;
  logic        sel_write;
  logic [31:0] prdata_d;
  logic        pslverr_d;
  logic        wr_commit;

  assign dec_idx = paddr_i[5:2];
  assign dec_hit = (paddr_i[31:6] == BASE_ADDR[31:6]) && (paddr_i[1:0] == 2'b00);
  assign dec_id  = (dec_idx == ID_OFFSET);
  assign dec_reg = ({1'b0, dec_idx} < NUM_REGS_W);
  assign dec_err = !dec_hit || !(dec_reg || dec_id) || (dec_id && pwrite_i);

  // With zero wait states READY is entered on the setup edge itself, so the
  // read mux must look at the live decode rather than the latched one.
  assign sel_idx   = (state_q == ST_IDLE) ? dec_idx  : idx_q;
  assign sel_id    = (state_q == ST_IDLE) ? dec_id   : id_q;
  assign sel_err   = (state_q == ST_IDLE) ? dec_err  : err_q;
  assign sel_write = (state_q == ST_IDLE) ? pwrite_i : write_q;

  always_comb begin
    prdata_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_idx == 4'(i)) prdata_d = regs_q[i];
    end
    if (sel_id) prdata_d = ID_VALUE;
    if (sel_err || sel_write) prdata_d = '0;
  end

`ifdef APB_REG_SLAVE_PSLVERR_EN
  assign pslverr_d = sel_err;
`else
  assign pslverr_d = 1'b0;
`endif

  assign wr_commit = (state_q == ST_READY) && psel_i && penable_i && write_q && !err_q;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      id_q      <= 1'b0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          prdata_q  <= '0;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          if (psel_i && !penable_i) begin
            idx_q   <= dec_idx;
            id_q    <= dec_id;
            err_q   <= dec_err;
            write_q <= pwrite_i;
            wdata_q <= pwdata_i;
            cnt_q   <= WAIT_INIT;
            if (WAIT_INIT == 4'd0) begin
              state_q   <= ST_READY;
              pready_q  <= 1'b1;
              prdata_q  <= prdata_d;
              pslverr_q <= pslverr_d;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!psel_i) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q   <= ST_READY;
              pready_q  <= 1'b1;
              prdata_q  <= prdata_d;
              pslverr_q <= pslverr_d;
            end
          end
        end
        ST_READY: begin
          // Leave on completion or abort; a setup-only cycle keeps the response held.
          if (!psel_i || penable_i) begin
            state_q   <= ST_IDLE;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          prdata_q  <= '0;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx_q == 4'(i)) regs_q[i] <= wdata_q;
      end
    end
  end

  assign prdata_o  = prdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign reg0_o    = regs_q[0];

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: three instances (0, 2 and 3 wait states), directed vector table,
// abort and mid-transfer reset sequences, then random traffic against an address-map model.
module tb_apb_reg_slave;
  localparam int          NI   = 3;
  localparam int          NREG = 4;
  localparam logic [31:0] BASE = 32'h0000_A000;
  localparam logic [31:0] IDV  = 32'hAB00_0001;
`ifdef APB_REG_SLAVE_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        psel    [NI];
  logic        penable [NI];
  logic        pwrite  [NI];
  logic [31:0] paddr   [NI];
  logic [31:0] pwdata  [NI];
  logic [31:0] prdata  [NI];
  logic        pready  [NI];
  logic        pslverr [NI];
  logic [31:0] reg0    [NI];

  always #5 pclk = ~pclk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    apb_reg_slave #(
      .BASE_ADDR  (BASE),
      .NUM_REGS   (NREG),
      .WAIT_CYCLES(gi == 0 ? 0 : (gi == 1 ? 2 : 3)),
      .ID_VALUE   (IDV)
    ) u_dut (
      .pclk     (pclk),
      .preset_n (preset_n),
      .psel_i   (psel[gi]),
      .penable_i(penable[gi]),
      .paddr_i  (paddr[gi]),
      .pwrite_i (pwrite[gi]),
      .pwdata_i (pwdata[gi]),
      .prdata_o (prdata[gi]),
      .pready_o (pready[gi]),
      .pslverr_o(pslverr[gi]),
      .reg0_o   (reg0[gi])
    );
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] mem [NI][16];

  typedef struct {
    int          k;
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t vecs[$];

  function automatic int wc(int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  // Address-map rules evaluated arithmetically on the byte address.
  function automatic bit model_err(logic [31:0] addr, bit wr);
    logic [31:0] off;
    if (addr < BASE || addr >= BASE + 32'd64) return 1'b1;
    off = addr - BASE;
    if (off % 4 != 0) return 1'b1;
    if (off == 32'd60) return wr;
    return off >= 32'(4 * NREG);
  endfunction

  function automatic logic [31:0] model_rd(int k, logic [31:0] addr, bit wr);
    logic [31:0] off;
    if (wr || model_err(addr, wr)) return 32'h0;
    off = addr - BASE;
    if (off == 32'd60) return IDV;
    return mem[k][off / 4];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 16; i++) mem[k][i] = 32'h0;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge after the completion edge with the bus idle.
  task automatic xfer(int k, logic [31:0] addr, bit wr, logic [31:0] wdata,
                      logic [31:0] exp_rd, bit exp_err);
    int cyc;
    psel[k] = 1'b1; penable[k] = 1'b0; paddr[k] = addr; pwrite[k] = wr; pwdata[k] = wdata;
    @(negedge pclk);
    penable[k] = 1'b1;
    cyc = 1;
    while (!pready[k] && cyc < 40) begin
      @(negedge pclk);
      cyc++;
    end
    $display("xfer inst=%0d %s addr=%h wdata=%h prdata=%h pslverr=%0d access_cycles=%0d",
             k, wr ? "WR" : "RD", addr, wdata, prdata[k], pslverr[k], cyc);
    check("access_cycles", 32'(cyc), 32'(wc(k) + 1));
    check("prdata", prdata[k], exp_rd);
    check("pslverr", 32'(pslverr[k]), 32'(exp_err && ERR_EN));
    @(negedge pclk);
    if (wr && !model_err(addr, wr)) mem[k][(addr - BASE) / 4] = wdata;
    psel[k] = 1'b0; penable[k] = 1'b0;
    check("pready_after", 32'(pready[k]), 32'h0);
    check("reg0", reg0[k], mem[k][0]);
  endtask

  task automatic check_all_zero(string tag);
    for (int k = 0; k < NI; k++) begin
      check({tag, "_prdata"}, prdata[k], 32'h0);
      check({tag, "_pready"}, 32'(pready[k]), 32'h0);
      check({tag, "_pslverr"}, 32'(pslverr[k]), 32'h0);
      check({tag, "_reg0"}, reg0[k], 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    logic [31:0] a;
    bit w;
    logic [31:0] d;
    int k;

    for (int i = 0; i < NI; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
    end
    clear_model();
    preset_n = 1'b0;
    repeat (3) @(negedge pclk);
    check_all_zero("reset");
    preset_n = 1'b1;
    @(negedge pclk);

    // Directed vectors: basic RW, adder-master read-modify-write, ID, and error cases.
    vecs.push_back('{0, 32'h0000_A000, 1'b0, 32'h0,         32'h0,         1'b0});
    vecs.push_back('{0, 32'h0000_A000, 1'b1, 32'h5,         32'h0,         1'b0});
    vecs.push_back('{0, 32'h0000_A000, 1'b0, 32'h0,         32'h5,         1'b0});
    vecs.push_back('{0, 32'h0000_A000, 1'b1, 32'h6,         32'h0,         1'b0});
    vecs.push_back('{0, 32'h0000_A000, 1'b0, 32'h0,         32'h6,         1'b0});
    vecs.push_back('{1, 32'h0000_A03C, 1'b0, 32'h0,         IDV,           1'b0});
    vecs.push_back('{0, 32'h0000_A03C, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b1});
    vecs.push_back('{0, 32'h0000_A03C, 1'b0, 32'h0,         IDV,           1'b0});
    vecs.push_back('{0, 32'h0000_A002, 1'b0, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{0, 32'h0000_B000, 1'b0, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{0, 32'h0000_A010, 1'b1, 32'h77,        32'h0,         1'b1});
    vecs.push_back('{0, 32'h0000_A001, 1'b1, 32'h99,        32'h0,         1'b1});
    vecs.push_back('{0, 32'h0000_B000, 1'b1, 32'hFFFF,      32'h0,         1'b1});
    vecs.push_back('{0, 32'h0000_A000, 1'b0, 32'h0,         32'h6,         1'b0});
    vecs.push_back('{0, 32'h0000_A004, 1'b1, 32'h1111_2222, 32'h0,         1'b0});
    vecs.push_back('{0, 32'h0000_A004, 1'b0, 32'h0,         32'h1111_2222, 1'b0});
    vecs.push_back('{1, 32'h0000_A00C, 1'b1, 32'hCAFE_F00D, 32'h0,         1'b0});
    vecs.push_back('{1, 32'h0000_A00C, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b0});
    vecs.push_back('{2, 32'h0000_A03C, 1'b0, 32'h0,         IDV,           1'b0});
    for (int i = 0; i < vecs.size(); i++)
      xfer(vecs[i].k, vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err);
    check("adder_reg0", reg0[0], 32'h6);

    // Abort: drop psel in the second wait cycle of a write on the 3-wait-state instance.
    psel[2] = 1'b1; penable[2] = 1'b0; paddr[2] = 32'h0000_A004; pwrite[2] = 1'b1;
    pwdata[2] = 32'h1234;
    @(negedge pclk);
    penable[2] = 1'b1;
    @(negedge pclk);
    psel[2] = 1'b0; penable[2] = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge pclk);
      if (pready[2]) seen++;
    end
    check("abort_pready_seen", 32'(seen), 32'h0);
    xfer(2, 32'h0000_A004, 1'b0, 32'h0, 32'h0, 1'b0);

    // Reset while a write to 0xA008 sits in the wait state.
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 32'h0000_A008; pwrite[1] = 1'b1;
    pwdata[1] = 32'h5555_AAAA;
    @(negedge pclk);
    penable[1] = 1'b1;
    #2 preset_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge pclk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    clear_model();
    @(negedge pclk);
    xfer(1, 32'h0000_A008, 1'b0, 32'h0, 32'h0, 1'b0);
    xfer(0, 32'h0000_A000, 1'b0, 32'h0, 32'h0, 1'b0);

    // Random traffic, sometimes back-to-back, sometimes with idle gaps.
    for (int n = 0; n < 200; n++) begin
      k = int'($urandom_range(0, NI - 1));
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, 15));
        3:       a = BASE + 32'($urandom_range(0, 63));
        4:       a = BASE ^ (32'h1 << $urandom_range(6, 31));
        default: a = BASE + 32'(4 * $urandom_range(0, NREG - 1));
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      xfer(k, a, w, d, model_rd(k, a, w), model_err(a, w));
      if ($urandom_range(0, 2) == 0) @(negedge pclk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
